calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Next-generation control unit for the X/Y/Z register plus ULA calculator datapath.
- Accepts a 4-bit func code through a start/busy/done handshake and drives the register-mode (tX, tY, tZ) and ULA-op (tULA) controls.
- Adds single-cycle ADD, SUB and SLY operations, and a multi-cycle shift-add multiply of parametrised width.
- Adds an X shift-left mode, a Z load-source select and illegal-code reporting.

Parameters:
- WIDTH, 8, datapath width; number of multiply iterations; legal values 2..32.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- func  in  4  operation code, sampled only when start is accepted.
- start  in  1  request; accepted only in IDLE.
- y_lsb  in  1  Y register bit 0, used during multiply.
- tX  out  2  X mode: 00 CLEAR, 01 LOAD, 10 HOLD, 11 SL (new).
- tY  out  3  Y mode: 000 CLEAR, 001 LOAD, 010 HOLD, 011 SL, 100 SR.
- tZ  out  2  Z mode: 00 CLEAR, 01 LOAD, 10 HOLD.
- tULA  out  1  0 ADD, 1 SUB.
- z_src  out  1  Z load source: 0 external input, 1 ULA result.
- busy  out  1  high while an operation is executing.
- done  out  1  one-cycle pulse in the final cycle of an operation.
- err  out  1  one-cycle pulse on an illegal func.

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - state = IDLE, counter = 0, captured func = 0000.
  - tX = 10, tY = 010, tZ = 10, tULA = 0, z_src = 0, busy = 0, done = 0, err = 0.
- IDLE:
  - All register controls at HOLD; tULA = 0; z_src = 0; busy = 0.
  - start = 1 captures func and moves to the operation state on the next edge.
- start while busy = 1 is ignored; func changes while busy are ignored.
- States: IDLE, EXEC, MUL_ADD, MUL_SHIFT, ERR.
- EXEC (one cycle; busy = 1, done = 1, then IDLE). Decode as (tX, tY, tZ, tULA, z_src):
  - 0000: 01, 000, 00, 0, 0
  - 0001: 01, 001, 10, 0, 0
  - 0010: 10, 001, 10, 0, 0
  - 0011: 10, 100, 10, 0, 0
  - 0100: 00, 000, 01, 0, 0
  - 0101 ADD: 10, 10, 01, 0, 1 (Z <= Z + X)
  - 0110 SUB: 10, 10, 01, 1, 1 (Z <= Z - X)
  - 0111 SLY: 10, 011, 10, 0, 0
- 1000 MUL (X = multiplicand, Y = multiplier, Z = accumulator, pre-cleared by software):
  - start moves to MUL_ADD with counter = 0.
  - MUL_ADD: tX = 10, tY = 010, tULA = 0, z_src = 1, tZ = y_lsb ? 01 : 10. tZ is the only Mealy output, combinational from y_lsb. Next state MUL_SHIFT.
  - MUL_SHIFT: tX = 11, tY = 100, tZ = 10, z_src = 1. counter increments. If counter == WIDTH-1 then done = 1 and next state is IDLE; else next state is MUL_ADD.
  - Total: 2*WIDTH cycles with busy = 1.
- 1001..1111: ERR state for one cycle; all controls HOLD; err = 1, done = 1, busy = 1; then IDLE.
- Timing: every output except the MUL_ADD tZ is decoded from registered state and captured func only, so it is glitch-free relative to clk.
- Earliest next start is the cycle after done (state IDLE). Minimum single-op issue interval is 2 cycles.
- Counter width CNT_W. The counter never wraps because the exit occurs at WIDTH-1. The counter is cleared on entry to MUL.

Test Plan:
- Reset with start = 1, func = 1000 held: outputs stay at reset values; after rst_n rises, the first edge with start = 1 enters MUL_ADD.
- func = 0101, start pulse: next cycle tX = 10, tY = 010, tZ = 01, tULA = 0, z_src = 1, done = 1, busy = 1; following cycle back to IDLE holds. Repeat with 0110: tULA = 1.
- func = 0001 then 0011 issued back-to-back at the earliest legal start each time: EXEC decodes 01/001/10 and 10/100/10 respectively. start asserted during EXEC is ignored.
- WIDTH = 4, MUL, y_lsb modelled from a Y register loaded with 4'b1011:
  - Eight busy cycles, alternating ADD and SHIFT.
  - tZ = 01 in ADD cycles 1, 2 and 4; tZ = 10 in ADD cycle 3.
  - done is high only in cycle 8.
  - With a datapath model, X = 5 gives Z = 55.
- func = 1010: one cycle with err = 1, done = 1 and all controls HOLD; then IDLE.
- rst_n pulled low during the third MUL cycle: outputs return to reset values immediately, with no done pulse; after release the block is in IDLE with counter = 0.

Source files
------------

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
//
// Control unit for the X/Y/Z register + ULA calculator datapath.
// A 4-bit operation code is accepted through a start/busy/done handshake and
// translated into register-mode controls (tX, tY, tZ), the ULA operation
// (tULA) and the Z load-source select (z_src).
//
// Operations:
//   0000..0111  single-cycle register/ULA operations (EXEC state)
//   1000        shift-add multiply, WIDTH iterations of ADD + SHIFT
//   1001..1111  illegal, reported with a one-cycle err pulse
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   func    in   [3:0] operation code, sampled when start is accepted
//   start   in   request, accepted only in IDLE
//   y_lsb   in   Y register bit 0, steers the multiply accumulate
//   tX      out  [1:0] X mode: 00 CLEAR, 01 LOAD, 10 HOLD, 11 SL
//   tY      out  [2:0] Y mode: 000 CLEAR, 001 LOAD, 010 HOLD, 011 SL, 100 SR
//   tZ      out  [1:0] Z mode: 00 CLEAR, 01 LOAD, 10 HOLD
//   tULA    out  ULA op: 0 ADD, 1 SUB
//   z_src   out  Z load source: 0 external input, 1 ULA result
//   busy    out  high while an operation is executing
//   done    out  one-cycle pulse in the final cycle of an operation
//   err     out  one-cycle pulse on an illegal func
// -----------------------------------------------------------------------------
module calc_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] func,
  input  logic       start,
  input  logic       y_lsb,
  output logic [1:0] tX,
  output logic [2:0] tY,
  output logic [1:0] tZ,
  output logic       tULA,
  output logic       z_src,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Register mode encodings
  localparam logic [1:0] X_CLEAR = 2'b00;
  localparam logic [1:0] X_LOAD  = 2'b01;
  localparam logic [1:0] X_HOLD  = 2'b10;
  localparam logic [1:0] X_SL    = 2'b11;

  localparam logic [2:0] Y_CLEAR = 3'b000;
  localparam logic [2:0] Y_LOAD  = 3'b001;
  localparam logic [2:0] Y_HOLD  = 3'b010;
  localparam logic [2:0] Y_SL    = 3'b011;
  localparam logic [2:0] Y_SR    = 3'b100;

  localparam logic [1:0] Z_CLEAR = 2'b00;
  localparam logic [1:0] Z_LOAD  = 2'b01;
  localparam logic [1:0] Z_HOLD  = 2'b10;

  localparam logic       ULA_ADD = 1'b0;
  localparam logic       ULA_SUB = 1'b1;

  localparam logic [3:0] FUNC_MUL = 4'b1000;

  // Iteration index of the final SHIFT cycle of a multiply
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EXEC      = 3'd1,
    S_MUL_ADD   = 3'd2,
    S_MUL_SHIFT = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       func_q,  func_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      func_q  <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // func is only captured in IDLE, so changes while busy have no effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          func_d = func;
          cnt_d  = '0;
          if (!func[3]) begin
            state_d = S_EXEC;
          end else if (func == FUNC_MUL) begin
            state_d = S_MUL_ADD;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_EXEC: begin
        state_d = S_IDLE;
      end

      S_MUL_ADD: begin
        state_d = S_MUL_SHIFT;
      end

      S_MUL_SHIFT: begin
        // The exit happens at WIDTH-1, so the counter tops out at WIDTH and
        // CNT_W = clog2(WIDTH+1) bits never wrap.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MUL_ADD;
        end
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // Everything is decoded from state_q/func_q/cnt_q except tZ in MUL_ADD, which
  // follows y_lsb combinationally so the accumulate sees the current Y bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    tX    = X_HOLD;
    tY    = Y_HOLD;
    tZ    = Z_HOLD;
    tULA  = ULA_ADD;
    z_src = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    err   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // all controls hold
      end

      S_EXEC: begin
        busy = 1'b1;
        done = 1'b1;
        // func_q[3] is always 0 here; a set bit leaves everything at HOLD.
        if (!func_q[3]) begin
          unique case (func_q[2:0])
            3'b000: begin tX = X_LOAD;  tY = Y_CLEAR; tZ = Z_CLEAR; end
            3'b001: begin tX = X_LOAD;  tY = Y_LOAD;  tZ = Z_HOLD;  end
            3'b010: begin tX = X_HOLD;  tY = Y_LOAD;  tZ = Z_HOLD;  end
            3'b011: begin tX = X_HOLD;  tY = Y_SR;    tZ = Z_HOLD;  end
            3'b100: begin tX = X_CLEAR; tY = Y_CLEAR; tZ = Z_LOAD;  end
            3'b101: begin
              // Z <= Z + X
              tX = X_HOLD; tY = Y_HOLD; tZ = Z_LOAD; tULA = ULA_ADD; z_src = 1'b1;
            end
            3'b110: begin
              // Z <= Z - X
              tX = X_HOLD; tY = Y_HOLD; tZ = Z_LOAD; tULA = ULA_SUB; z_src = 1'b1;
            end
            3'b111: begin tX = X_HOLD;  tY = Y_SL;    tZ = Z_HOLD;  end
            default: begin end
          endcase
        end
      end

      S_MUL_ADD: begin
        busy  = 1'b1;
        z_src = 1'b1;
        tULA  = ULA_ADD;
        tZ    = y_lsb ? Z_LOAD : Z_HOLD;
      end

      S_MUL_SHIFT: begin
        busy  = 1'b1;
        z_src = 1'b1;
        tX    = X_SL;
        tY    = Y_SR;
        done  = (cnt_q == LAST_CNT);
      end

      S_ERR: begin
        busy = 1'b1;
        done = 1'b1;
        err  = 1'b1;
      end

      default: begin end
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
//
// Directed bench for calc_sequencer with WIDTH = 4. A small X/Y/Z/ULA datapath
// model reacts to the control outputs so the multiply result can be checked.
// All outputs are packed as {tX, tY, tZ, tULA, z_src, busy, done, err}.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;

  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] func = 4'b0000;
  logic       start = 1'b0;
  logic       y_lsb;
  logic [1:0] tX;
  logic [2:0] tY;
  logic [1:0] tZ;
  logic       tULA;
  logic       z_src;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Expected packed output vectors
  localparam logic [11:0] V_IDLE  = 12'b10_010_10_0_0_0_0_0;
  localparam logic [11:0] V_ADD   = 12'b10_010_01_0_1_1_1_0;
  localparam logic [11:0] V_SUB   = 12'b10_010_01_1_1_1_1_0;
  localparam logic [11:0] V_F0001 = 12'b01_001_10_0_0_1_1_0;
  localparam logic [11:0] V_F0010 = 12'b10_001_10_0_0_1_1_0;
  localparam logic [11:0] V_F0011 = 12'b10_100_10_0_0_1_1_0;
  localparam logic [11:0] V_F0100 = 12'b00_000_01_0_0_1_1_0;
  localparam logic [11:0] V_ERR   = 12'b10_010_10_0_0_1_1_1;
  localparam logic [11:0] V_MA1   = 12'b10_010_01_0_1_1_0_0;
  localparam logic [11:0] V_MA0   = 12'b10_010_10_0_1_1_0_0;
  localparam logic [11:0] V_MS    = 12'b11_100_10_0_1_1_0_0;
  localparam logic [11:0] V_MSL   = 12'b11_100_10_0_1_1_1_0;

  wire [11:0] out_v = {tX, tY, tZ, tULA, z_src, busy, done, err};

  calc_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .func  (func),
    .start (start),
    .y_lsb (y_lsb),
    .tX    (tX),
    .tY    (tY),
    .tZ    (tZ),
    .tULA  (tULA),
    .z_src (z_src),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Datapath model driven by the control outputs
  logic [7:0] in_bus = 8'd0;
  logic [7:0] x_m = 8'd0;
  logic [3:0] y_m = 4'd0;
  logic [7:0] z_m = 8'd0;

  assign y_lsb = y_m[0];

  always @(posedge clk) begin
    case (tX)
      2'b00: x_m <= 8'd0;
      2'b01: x_m <= in_bus;
      2'b11: x_m <= x_m << 1;
      default: x_m <= x_m;
    endcase
    case (tY)
      3'b000: y_m <= 4'd0;
      3'b001: y_m <= in_bus[3:0];
      3'b011: y_m <= y_m << 1;
      3'b100: y_m <= y_m >> 1;
      default: y_m <= y_m;
    endcase
    case (tZ)
      2'b00: z_m <= 8'd0;
      2'b01: z_m <= z_src ? (tULA ? z_m - x_m : z_m + x_m) : in_bus;
      default: z_m <= z_m;
    endcase
  end

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    func  = 4'b1000;
    #1;
    checks++;
    if (out_v !== V_IDLE) begin
      errors++;
      $display("FAIL reset_initial outputs=%b expected=%b", out_v, V_IDLE);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_v !== V_IDLE) begin
        errors++;
        $display("FAIL reset_held cycle=%0d outputs=%b expected=%b", i, out_v, V_IDLE);
      end
    end
    rst_n = 1'b1;
    step();
    // First edge with start=1 enters MUL_ADD; tZ depends on y_lsb so mask it
    checks++;
    if ({out_v[11:7], out_v[4:0]} !== {V_MA0[11:7], V_MA0[4:0]}) begin
      errors++;
      $display("FAIL reset_first_mul outputs=%b expected=%b (tZ ignored)", out_v, V_MA0);
    end
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_v !== V_IDLE) begin
      errors++;
      $display("FAIL reset_abort outputs=%b expected=%b", out_v, V_IDLE);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add_sub();
    func  = 4'b0101;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (out_v !== V_ADD) begin
      errors++;
      $display("FAIL add_exec outputs=%b expected=%b", out_v, V_ADD);
    end
    step();
    checks++;
    if (out_v !== V_IDLE) begin
      errors++;
      $display("FAIL add_idle outputs=%b expected=%b", out_v, V_IDLE);
    end
    func  = 4'b0110;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (out_v !== V_SUB) begin
      errors++;
      $display("FAIL sub_exec outputs=%b expected=%b", out_v, V_SUB);
    end
    step();
    checks++;
    if (out_v !== V_IDLE) begin
      errors++;
      $display("FAIL sub_idle outputs=%b expected=%b", out_v, V_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    func  = 4'b0001;
    start = 1'b1;
    step();
    checks++;
    if (out_v !== V_F0001) begin
      errors++;
      $display("FAIL b2b_first outputs=%b expected=%b", out_v, V_F0001);
    end
    // start held and func changed during EXEC: must be ignored
    func = 4'b0011;
    step();
    checks++;
    if (out_v !== V_IDLE) begin
      errors++;
      $display("FAIL b2b_ignored outputs=%b expected=%b", out_v, V_IDLE);
    end
    step();
    start = 1'b0;
    checks++;
    if (out_v !== V_F0011) begin
      errors++;
      $display("FAIL b2b_second outputs=%b expected=%b", out_v, V_F0011);
    end
    step();
    checks++;
    if (out_v !== V_IDLE) begin
      errors++;
      $display("FAIL b2b_idle outputs=%b expected=%b", out_v, V_IDLE);
    end
  endtask

  task automatic test_illegal();
    func  = 4'b1010;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (out_v !== V_ERR) begin
      errors++;
      $display("FAIL illegal_err outputs=%b expected=%b", out_v, V_ERR);
    end
    step();
    checks++;
    if (out_v !== V_IDLE) begin
      errors++;
      $display("FAIL illegal_idle outputs=%b expected=%b", out_v, V_IDLE);
    end
  endtask

  // Load Z=0, X=5, Y=1011 through the datapath using single-cycle ops
  task automatic load_operands();
    in_bus = 8'd0;
    func   = 4'b0100;
    start  = 1'b1;
    step();
    start  = 1'b0;
    checks++;
    if (out_v !== V_F0100) begin
      errors++;
      $display("FAIL load_f0100 outputs=%b expected=%b", out_v, V_F0100);
    end
    step();
    in_bus = 8'd5;
    func   = 4'b0001;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    in_bus = 8'd11;
    func   = 4'b0010;
    start  = 1'b1;
    step();
    start  = 1'b0;
    checks++;
    if (out_v !== V_F0010) begin
      errors++;
      $display("FAIL load_f0010 outputs=%b expected=%b", out_v, V_F0010);
    end
    step();
    in_bus = 8'd0;
  endtask

  task automatic test_multiply();
    logic [11:0] exp_v;
    load_operands();
    func  = 4'b1000;
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      start = 1'b0;
      case (k)
        1, 2 + 0: exp_v = (k == 1) ? V_MA1 : V_MS;
        3:        exp_v = V_MA1;
        5:        exp_v = V_MA0;
        7:        exp_v = V_MA1;
        8:        exp_v = V_MSL;
        default:  exp_v = V_MS;
      endcase
      checks++;
      if (out_v !== exp_v) begin
        errors++;
        $display("FAIL mul_cycle%0d outputs=%b expected=%b", k, out_v, exp_v);
      end
    end
    step();
    checks++;
    if (out_v !== V_IDLE) begin
      errors++;
      $display("FAIL mul_idle outputs=%b expected=%b", out_v, V_IDLE);
    end
    checks++;
    if (z_m !== 8'd55) begin
      errors++;
      $display("FAIL mul_result z=%0d expected=55", z_m);
    end
  endtask

  task automatic test_reset_mid_mul();
    load_operands();
    func  = 4'b1000;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    // third MUL cycle (second ADD): pull reset mid-cycle
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy busy=%b expected=1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_v !== V_IDLE) begin
      errors++;
      $display("FAIL midrst_immediate outputs=%b expected=%b", out_v, V_IDLE);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_v !== V_IDLE) begin
        errors++;
        $display("FAIL midrst_held cycle=%0d outputs=%b expected=%b", i, out_v, V_IDLE);
      end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (out_v !== V_IDLE) begin
      errors++;
      $display("FAIL midrst_release outputs=%b expected=%b", out_v, V_IDLE);
    end
    // A full 8-cycle multiply afterwards shows the counter restarted from 0
    test_multiply();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_illegal();
    test_multiply();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
